// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory port arbiter.
//   ARB_XLEN     default address/data width
//   ARB_BE_W     byte-enable width
//   arb_state_t  arbiter FSM encoding
//   starve_width counter width able to hold 0..max_cnt
package mem_port_arbiter_pkg;

   localparam int ARB_XLEN = 32;
   localparam int ARB_BE_W = 4;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_BUSY_I = 2'd1,
      ARB_BUSY_D = 2'd2
   } arb_state_t;

   function automatic int starve_width(input int max_cnt);
      return $clog2(max_cnt + 1);
   endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive data grants made while a fetch waits.
//   clk_i, rst_i  clock, async active-high reset
//   inc           count one more data grant (ignored once saturated)
//   clr           return to zero (wins over inc)
//   sat           count has reached MAX; fetch must win the next tie
module arb_starve_ctr
   import mem_port_arbiter_pkg::*;
#(
   parameter int MAX = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic inc,
   input  logic clr,
   output logic sat
);

   localparam int CW = starve_width(MAX);

   logic [CW-1:0] cnt;

   assign sat = (cnt == CW'(MAX));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && !sat) begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported instruction/data memory between the fetch stage
// and the MEM-stage load/store path, one outstanding bus transaction at a time.
//   clk_i, rst_i              clock, async active-high reset
//   if_*                      fetch request/grant/response
//   flush_if_i                discard the in-flight fetch response
//   d_*                       load/store request/grant/response
//   bus_*                     memory request held until bus_ack_i
//   stall_if_o, stall_mem_o   hold requests toward pipectrl
//   conflict_cnt_o            idle cycles with both requests pending
// Optional macro ARB_PERF_CNT_EN builds the conflict counter; without it
// conflict_cnt_o is tied to zero.
//
// state      | meaning
// -----------+-----------------------------------------------
// ARB_IDLE   | no transaction on the bus; grants decided here
// ARB_BUSY_I | fetch transaction on the bus, waiting for ack
// ARB_BUSY_D | load/store transaction on the bus, waiting for ack
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int XLEN       = ARB_XLEN,
   parameter int STARVE_MAX = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                if_req_i,
   input  logic [XLEN-1:0]     if_addr_i,
   input  logic                flush_if_i,
   output logic                if_gnt_o,
   output logic                if_rvalid_o,
   output logic [XLEN-1:0]     if_rdata_o,
   input  logic                d_req_i,
   input  logic                d_we_i,
   input  logic [XLEN-1:0]     d_addr_i,
   input  logic [XLEN-1:0]     d_wdata_i,
   input  logic [ARB_BE_W-1:0] d_be_i,
   output logic                d_gnt_o,
   output logic                d_rvalid_o,
   output logic [XLEN-1:0]     d_rdata_o,
   output logic                bus_req_o,
   output logic                bus_we_o,
   output logic [XLEN-1:0]     bus_addr_o,
   output logic [XLEN-1:0]     bus_wdata_o,
   output logic [ARB_BE_W-1:0] bus_be_o,
   input  logic                bus_ack_i,
   input  logic [XLEN-1:0]     bus_rdata_i,
   output logic                stall_if_o,
   output logic                stall_mem_o,
   output logic [31:0]         conflict_cnt_o
);

   arb_state_t state_q, state_d;

   logic                starve_sat;
   logic                drop_q;
   logic                if_rvalid_q, d_rvalid_q;
   logic [XLEN-1:0]     if_rdata_q, d_rdata_q;
   logic                bus_req_q, bus_we_q;
   logic [XLEN-1:0]     bus_addr_q, bus_wdata_q;
   logic [ARB_BE_W-1:0] bus_be_q;
   logic                ack_i_edge, ack_d_edge;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ARB_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Data normally wins a tie; a saturated starvation count hands it to fetch.
   always_comb begin
      state_d  = state_q;
      if_gnt_o = 1'b0;
      d_gnt_o  = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (d_req_i && !(if_req_i && starve_sat)) begin
               d_gnt_o = 1'b1;
               state_d = ARB_BUSY_D;
            end else if (if_req_i) begin
               if_gnt_o = 1'b1;
               state_d  = ARB_BUSY_I;
            end
         end
         ARB_BUSY_I, ARB_BUSY_D: begin
            if (bus_ack_i) begin
               state_d = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   arb_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc   (d_gnt_o & if_req_i),
      .clr   (if_gnt_o | (d_gnt_o & ~if_req_i)),
      .sat   (starve_sat)
   );

   // An ack seen while idle belongs to an abandoned transaction and is dropped.
   assign ack_i_edge = (state_q == ARB_BUSY_I) && bus_ack_i;
   assign ack_d_edge = (state_q == ARB_BUSY_D) && bus_ack_i;

   // Bus fields are only written on a grant, so they stay put until the ack.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         bus_be_q    <= '0;
      end else if (d_gnt_o) begin
         bus_req_q   <= 1'b1;
         bus_we_q    <= d_we_i;
         bus_addr_q  <= d_addr_i;
         bus_wdata_q <= d_wdata_i;
         bus_be_q    <= d_be_i;
      end else if (if_gnt_o) begin
         bus_req_q   <= 1'b1;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= if_addr_i;
         bus_wdata_q <= '0;
         bus_be_q    <= '1;
      end else if (ack_i_edge || ack_d_edge) begin
         bus_req_q   <= 1'b0;
      end
   end

   // A flush arriving on the ack cycle itself must also suppress the pulse.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         drop_q      <= 1'b0;
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
      end else begin
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
         if (ack_i_edge) begin
            if_rdata_q  <= bus_rdata_i;
            if_rvalid_q <= ~(drop_q | flush_if_i);
            drop_q      <= 1'b0;
         end else if ((state_q == ARB_BUSY_I) && flush_if_i) begin
            drop_q <= 1'b1;
         end
         if (ack_d_edge) begin
            d_rdata_q  <= bus_rdata_i;
            d_rvalid_q <= 1'b1;
         end
      end
   end

   assign bus_req_o   = bus_req_q;
   assign bus_we_o    = bus_we_q;
   assign bus_addr_o  = bus_addr_q;
   assign bus_wdata_o = bus_wdata_q;
   assign bus_be_o    = bus_be_q;
   assign if_rvalid_o = if_rvalid_q;
   assign if_rdata_o  = if_rdata_q;
   assign d_rvalid_o  = d_rvalid_q;
   assign d_rdata_o   = d_rdata_q;

   assign stall_if_o  = if_req_i & ~if_rvalid_o;
   assign stall_mem_o = d_req_i & ~d_rvalid_o;

`ifdef ARB_PERF_CNT_EN
   logic [31:0] conflict_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         conflict_q <= '0;
      end else if ((state_q == ARB_IDLE) && if_req_i && d_req_i) begin
         conflict_q <= conflict_q + 32'd1;
      end
   end

   assign conflict_cnt_o = conflict_q;
`else
   assign conflict_cnt_o = '0;
`endif

endmodule
